// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction controller.
// Contents: state enum, coin encodings, coin_value() decoder.
package vend_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_VEND    = 3'd1,
      S_CHG_REQ = 3'd2,
      S_CHG_GAP = 3'd3,
      S_FAULT   = 3'd4
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_ONE  = 2'b01;
   localparam logic [1:0] COIN_TWO  = 2'b10;
   localparam logic [1:0] COIN_BAD  = 2'b11;

   // Credit value of a coin code; invalid and empty codes are worth nothing.
   function automatic logic [1:0] coin_value(input logic [1:0] coin);
      case (coin)
         COIN_ONE: coin_value = 2'd1;
         COIN_TWO: coin_value = 2'd2;
         default:  coin_value = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Acknowledge timeout counter for the vending controller.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_clr         - restart count (new request or ack)
//   i_run         - count while a request is outstanding
//   o_expired_c   - combinational: request has been high TIMEOUT_CYC cycles
module vend_ack_timer #(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_run,
   output logic o_expired_c
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_cnt;

   // Counts cycles of the outstanding request; saturates at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_run && (r_cnt != TW'(TIMEOUT_CYC - 1))) begin
         r_cnt <= r_cnt + TW'(1);
      end
   end

   // Count is 0 in the first request cycle, so this flags the TIMEOUT_CYC-th.
   assign o_expired_c = i_run && (r_cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: accumulates coin credit, vends at PRICE,
// pays change/refunds one unit per hopper handshake, handles cancel.
// Optional macro VEND_TIMEOUT_EN: ack timeout drives a sticky FAULT state.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   coin[1:0]           - 00 none, 01 one unit, 10 two units, 11 invalid
//   cancel              - refund request (honoured in IDLE only)
//   disp_req / disp_ack - dispenser handshake
//   chg_req / chg_ack   - change hopper handshake, one unit per ack
//   credit[CW-1:0]      - accumulated credit
//   busy                - not IDLE
//   coin_rej            - one-cycle pulse per rejected coin
//   err                 - sticky fault flag
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned PRICE       = 3,
   parameter int unsigned CW          = 4,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    coin,
   input  logic          cancel,
   output logic          disp_req,
   input  logic          disp_ack,
   output logic          chg_req,
   input  logic          chg_ack,
   output logic [CW-1:0] credit,
   output logic          busy,
   output logic          coin_rej,
   output logic          err
);

   state_t        r_state, w_next_state;
   logic [CW-1:0] r_credit, w_next_credit;
   logic [CW-1:0] r_change, w_next_change;
   logic [CW-1:0] w_total;
   logic          r_disp_req, w_next_disp_req;
   logic          r_chg_req, w_next_chg_req;
   logic          r_busy, w_next_busy;
   logic          r_coin_rej, w_next_coin_rej;
   logic          w_tmr_expired;

`ifdef VEND_TIMEOUT_EN
   logic r_err, w_next_err;
   logic w_tmr_clr, w_tmr_run;

   // Restart on every new request and on every honoured ack.
   assign w_tmr_clr = (w_next_disp_req & ~r_disp_req) |
                      (w_next_chg_req & ~r_chg_req)   |
                      (r_disp_req & disp_ack)         |
                      (r_chg_req & chg_ack);
   assign w_tmr_run = r_disp_req | r_chg_req;

   vend_ack_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_ack_timer (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_tmr_clr),
      .i_run       (w_tmr_run),
      .o_expired_c (w_tmr_expired)
   );
`else
   logic w_unused_tmo;

   // Timeout parameter has no effect in this build.
   assign w_unused_tmo  = ^32'(TIMEOUT_CYC);
   assign w_tmr_expired = 1'b0;
`endif

   // Credit after this cycle's coin; invalid coins are worth 0.
   assign w_total = r_credit + CW'(coin_value(coin));

   // Next-state, next-credit/change and next-output decode.
   always_comb begin
      w_next_state    = r_state;
      w_next_credit   = r_credit;
      w_next_change   = r_change;
      w_next_coin_rej = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_next_coin_rej = (coin == COIN_BAD);
            // Cancel wins over vend; a same-cycle coin is counted first.
            if (cancel) begin
               w_next_change = w_total;
               w_next_credit = '0;
               if (w_total != '0) begin
                  w_next_state = S_CHG_REQ;
               end
            end else if (w_total >= CW'(PRICE)) begin
               w_next_change = w_total - CW'(PRICE);
               w_next_credit = '0;
               w_next_state  = S_VEND;
            end else begin
               w_next_credit = w_total;
            end
         end
         S_VEND: begin
            w_next_coin_rej = (coin != COIN_NONE);
            if (disp_ack) begin
               w_next_state = (r_change != '0) ? S_CHG_REQ : S_IDLE;
            end else if (w_tmr_expired) begin
               w_next_state = S_FAULT;
            end
         end
         S_CHG_REQ: begin
            w_next_coin_rej = (coin != COIN_NONE);
            if (chg_ack) begin
               w_next_change = r_change - CW'(1);
               w_next_state  = (r_change != CW'(1)) ? S_CHG_GAP : S_IDLE;
            end else if (w_tmr_expired) begin
               w_next_state = S_FAULT;
            end
         end
         S_CHG_GAP: begin
            w_next_coin_rej = (coin != COIN_NONE);
            w_next_state    = S_CHG_REQ;
         end
         S_FAULT: begin
            w_next_coin_rej = (coin != COIN_NONE);
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      // Requests are decoded from the next state so they are registered.
      w_next_disp_req = (w_next_state == S_VEND);
      w_next_chg_req  = (w_next_state == S_CHG_REQ);
      w_next_busy     = (w_next_state != S_IDLE);
   end

`ifdef VEND_TIMEOUT_EN
   assign w_next_err = r_err | (w_next_state == S_FAULT);
`endif

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_credit   <= '0;
         r_change   <= '0;
         r_disp_req <= 1'b0;
         r_chg_req  <= 1'b0;
         r_busy     <= 1'b0;
         r_coin_rej <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_credit   <= w_next_credit;
         r_change   <= w_next_change;
         r_disp_req <= w_next_disp_req;
         r_chg_req  <= w_next_chg_req;
         r_busy     <= w_next_busy;
         r_coin_rej <= w_next_coin_rej;
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_next_err;
      end
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign disp_req = r_disp_req;
   assign chg_req  = r_chg_req;
   assign credit   = r_credit;
   assign busy     = r_busy;
   assign coin_rej = r_coin_rej;

endmodule
